// File: rtl/mux_lane_sched_pkg.sv
// Shared types and constants for the two-source lane scheduler.
// Holds the FSM state encoding, lane geometry and grant encodings.
package mux_lane_sched_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int DATA_W = LANES * LANE_W;

  localparam logic [3:0] CNT_MAX = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
  } state_e;

  // Grant encoding doubles as the lane-mux select value.
  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  // A burst setting of zero behaves as a burst of one.
  function automatic logic [3:0] burst_limit(input logic [3:0] cfg);
    return (cfg == 4'd0) ? 4'd1 : cfg;
  endfunction

endpackage

// File: rtl/mux_lane_sched_lane_mux.sv
// 4-lane 2:1 byte multiplexer with blanking.
// Each lane independently picks A or B; blank forces every lane to zero.
module mux_lane_sched_lane_mux
  import mux_lane_sched_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sel,
  input  logic              i_blank,
  output logic [DATA_W-1:0] o_y
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign o_y[k*LANE_W +: LANE_W] =
      i_blank ? '0 : (i_sel ? i_b[k*LANE_W +: LANE_W] : i_a[k*LANE_W +: LANE_W]);
  end

endmodule

// File: rtl/mux_lane_sched.sv
// Two-source burst-fair scheduler feeding a registered 4-lane output word.
// A 3-state FSM grants A or B, bounding consecutive beats by cfg_burst.
module mux_lane_sched
  import mux_lane_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic [3:0]        cfg_burst,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              sel,
  output logic              blank
);

  state_e            r_state;
  state_e            w_state_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;
  logic [3:0]        w_cnt_inc;
  grant_e            r_last_grant;
  grant_e            r_sel_hold;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              w_adv;
  logic              w_accept;
  logic              w_cur_valid;
  logic              w_oth_valid;
  logic [DATA_W-1:0] w_mux_data;

  // The output stage can take a new word when empty or being drained.
  assign w_adv    = !r_out_valid || out_ready;
  assign a_ready  = (r_state == ST_GNT_A) && w_adv;
  assign b_ready  = (r_state == ST_GNT_B) && w_adv;
  assign w_accept = (a_valid && a_ready) || (b_valid && b_ready);

  always_comb begin
    sel = r_sel_hold;
    if (r_state == ST_GNT_A)      sel = GRANT_A;
    else if (r_state == ST_GNT_B) sel = GRANT_B;
  end

  // Blanking the mux when nothing is accepted lets the register clear to zero.
  mux_lane_sched_lane_mux u_lane_mux (
    .i_a     (a_data),
    .i_b     (b_data),
    .i_sel   (sel),
    .i_blank (!w_accept),
    .o_y     (w_mux_data)
  );

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign blank     = !r_out_valid;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cur_valid  = (r_state == ST_GNT_A) ? a_valid : b_valid;
    w_oth_valid  = (r_state == ST_GNT_A) ? b_valid : a_valid;
    w_cnt_inc    = (w_cur_valid && (r_cnt != CNT_MAX)) ? r_cnt + 4'd1 : r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_next = 4'd0;
        if (a_valid && b_valid)
          w_state_next = (r_last_grant == GRANT_B) ? ST_GNT_A : ST_GNT_B;
        else if (a_valid)
          w_state_next = ST_GNT_A;
        else if (b_valid)
          w_state_next = ST_GNT_B;
      end
      ST_GNT_A, ST_GNT_B: begin
        if (w_adv) begin
          w_cnt_next = w_cnt_inc;
          if (!w_cur_valid && !w_oth_valid) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = 4'd0;
          end else if (w_oth_valid &&
                       (!w_cur_valid || (w_cnt_inc >= burst_limit(cfg_burst)))) begin
            w_state_next = (r_state == ST_GNT_A) ? ST_GNT_B : ST_GNT_A;
            w_cnt_next   = 4'd0;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_last_grant <= GRANT_B;
      r_sel_hold   <= GRANT_A;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_state_next == ST_GNT_A) begin
        r_last_grant <= GRANT_A;
        r_sel_hold   <= GRANT_A;
      end else if (w_state_next == ST_GNT_B) begin
        r_last_grant <= GRANT_B;
        r_sel_hold   <= GRANT_B;
      end
      if (w_adv) begin
        r_out_valid <= w_accept;
        r_out_data  <= w_mux_data;
      end
    end
  end

endmodule
